// File: rtl/r2sdf_stage1_pkg.sv
// Shared types, widths and twiddle ROM for stage 1
// of the 32-point radix-2 SDF FFT.
package r2sdf_stage1_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    FIRST   = 2'b01,
    SECOND  = 2'b10,
    WAITING = 2'b11
  } state_e;

  localparam int N_PT  = 32;
  localparam int IN_W  = 8;
  localparam int DL_W  = 9;
  localparam int OUT_W = 14;
  localparam int TW_W  = 8;
  localparam int K_W   = 4;
  localparam int IDX_W = 5;

  typedef struct packed {
    logic signed [DL_W-1:0] r;
    logic signed [DL_W-1:0] i;
  } dl_t;

  typedef struct packed {
    logic signed [TW_W-1:0] r;
    logic signed [TW_W-1:0] i;
  } tw_t;

  // W32^k in 2.6, rounded to nearest
  function automatic tw_t twiddle(
    input logic [K_W-1:0] k
  );
    tw_t w;
    unique case (k)
      4'd0:  w = '{ 8'sd64,   8'sd0};
      4'd1:  w = '{ 8'sd63,  -8'sd12};
      4'd2:  w = '{ 8'sd59,  -8'sd24};
      4'd3:  w = '{ 8'sd53,  -8'sd36};
      4'd4:  w = '{ 8'sd45,  -8'sd45};
      4'd5:  w = '{ 8'sd36,  -8'sd53};
      4'd6:  w = '{ 8'sd24,  -8'sd59};
      4'd7:  w = '{ 8'sd12,  -8'sd63};
      4'd8:  w = '{ 8'sd0,   -8'sd64};
      4'd9:  w = '{-8'sd12,  -8'sd63};
      4'd10: w = '{-8'sd24,  -8'sd59};
      4'd11: w = '{-8'sd36,  -8'sd53};
      4'd12: w = '{-8'sd45,  -8'sd45};
      4'd13: w = '{-8'sd53,  -8'sd36};
      4'd14: w = '{-8'sd59,  -8'sd24};
      4'd15: w = '{-8'sd63,  -8'sd12};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/BUTTERFLY_R2_1.sv
// Radix-2 SDF butterfly: sum in FIRST, twiddle
// multiply of the stored difference in SECOND.
module BUTTERFLY_R2_1
  import r2sdf_stage1_pkg::*;
(
  input  state_e                  i_state,
  input  logic signed [DL_W-1:0]  i_a_r,
  input  logic signed [DL_W-1:0]  i_a_i,
  input  logic signed [DL_W-1:0]  i_b_r,
  input  logic signed [DL_W-1:0]  i_b_i,
  input  logic signed [TW_W-1:0]  i_wn_r,
  input  logic signed [TW_W-1:0]  i_wn_i,
  output logic signed [OUT_W-1:0] o_y_r,
  output logic signed [OUT_W-1:0] o_y_i,
  output logic signed [DL_W-1:0]  o_sr_r,
  output logic signed [DL_W-1:0]  o_sr_i
);

  localparam int MW = OUT_W + 1;

  logic signed [DL_W-1:0] w_sum_r;
  logic signed [DL_W-1:0] w_sum_i;
  logic signed [DL_W-1:0] w_dif_r;
  logic signed [DL_W-1:0] w_dif_i;
  logic signed [MW-1:0]   w_m_r;
  logic signed [MW-1:0]   w_m_i;

  assign w_sum_r = i_a_r + i_b_r;
  assign w_sum_i = i_a_i + i_b_i;
  assign w_dif_r = i_b_r - i_a_r;
  assign w_dif_i = i_b_i - i_a_i;

  // Only bits [14:0] of the product survive
  assign w_m_r = MW'(i_b_r) * MW'(i_wn_r)
               - MW'(i_b_i) * MW'(i_wn_i);
  assign w_m_i = MW'(i_b_r) * MW'(i_wn_i)
               + MW'(i_b_i) * MW'(i_wn_r);

  always_comb begin
    o_y_r  = '0;
    o_y_i  = '0;
    o_sr_r = i_a_r;
    o_sr_i = i_a_i;
    unique case (i_state)
      IDLE, WAITING: begin
        o_sr_r = i_a_r;
        o_sr_i = i_a_i;
      end
      FIRST: begin
        o_y_r  = {w_sum_r, 5'b0};
        o_y_i  = {w_sum_i, 5'b0};
        o_sr_r = w_dif_r;
        o_sr_i = w_dif_i;
      end
      SECOND: begin
        o_y_r  = OUT_W'(w_m_r >>> 1);
        o_y_i  = OUT_W'(w_m_i >>> 1);
        o_sr_r = '0;
        o_sr_i = '0;
      end
    endcase
  end

endmodule

// File: rtl/r2sdf_stage1.sv
// Stage 1 of a 32-point radix-2 SDF FFT: delay line,
// sample counter, FSM, twiddle ROM and output register.
module r2sdf_stage1
  import r2sdf_stage1_pkg::*;
#(
  parameter int N = N_PT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_r,
  input  logic signed [IN_W-1:0]  in_i,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_r,
  output logic signed [OUT_W-1:0] out_i,
  output logic [IDX_W-1:0]        out_idx
);

  localparam int D = N / 2;

  state_e                  r_state;
  logic [K_W-1:0]          r_k;
  dl_t                     r_dl [D];
  logic                    r_out_valid;
  logic signed [OUT_W-1:0] r_out_r;
  logic signed [OUT_W-1:0] r_out_i;
  logic [IDX_W-1:0]        r_out_idx;

  logic                    w_acc;
  logic                    w_adv;
  logic                    w_last;
  tw_t                     w_wn;
  logic signed [OUT_W-1:0] w_bf_r;
  logic signed [OUT_W-1:0] w_bf_i;
  logic signed [DL_W-1:0]  w_sr_r;
  logic signed [DL_W-1:0]  w_sr_i;

  assign in_ready = (r_state != SECOND);
  assign w_acc    = in_valid && in_ready;
  // SECOND drains the delay line without waiting for input
  assign w_adv    = w_acc || (r_state == SECOND);
  assign w_last   = (r_k == K_W'(D - 1));
  assign w_wn     = twiddle(r_k);

  BUTTERFLY_R2_1 u_bfly (
    .i_state (r_state),
    .i_a_r   ({in_r[IN_W-1], in_r}),
    .i_a_i   ({in_i[IN_W-1], in_i}),
    .i_b_r   (r_dl[D-1].r),
    .i_b_i   (r_dl[D-1].i),
    .i_wn_r  (w_wn.r),
    .i_wn_i  (w_wn.i),
    .o_y_r   (w_bf_r),
    .o_y_i   (w_bf_i),
    .o_sr_r  (w_sr_r),
    .o_sr_i  (w_sr_i)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_out_valid <= 1'b0;
      r_out_r     <= '0;
      r_out_i     <= '0;
      r_out_idx   <= '0;
      for (int i = 0; i < D; i++) r_dl[i] <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_adv) begin
        for (int i = D - 1; i > 0; i--) r_dl[i] <= r_dl[i-1];
        r_dl[0] <= '{w_sr_r, w_sr_i};
        r_k     <= r_k + K_W'(1);
        unique case (r_state)
          IDLE: r_state <= WAITING;
          WAITING: begin
            if (w_last) r_state <= FIRST;
          end
          FIRST: begin
            r_out_valid <= 1'b1;
            r_out_r     <= w_bf_r;
            r_out_i     <= w_bf_i;
            r_out_idx   <= {1'b0, r_k};
            if (w_last) r_state <= SECOND;
          end
          SECOND: begin
            r_out_valid <= 1'b1;
            r_out_r     <= w_bf_r;
            r_out_i     <= w_bf_i;
            r_out_idx   <= {1'b1, r_k};
            if (w_last) r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_r     = r_out_r;
  assign out_i     = r_out_i;
  assign out_idx   = r_out_idx;

endmodule

// File: tb/tb_r2sdf_stage1.sv
// Bench for r2sdf_stage1: frames checked against a
// DIF stage-1 reference built from complex arithmetic.
module tb_r2sdf_stage1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [7:0]  in_r = '0;
  logic signed [7:0]  in_i = '0;
  logic               out_valid;
  logic signed [13:0] out_r;
  logic signed [13:0] out_i;
  logic [4:0]         out_idx;

  int n_chk = 0;
  int n_err = 0;
  int lo_cnt = 0;
  int q_idx[$];
  int q_r[$];
  int q_i[$];
  int xr[32];
  int xi[32];

  always #5 clk = ~clk;

  r2sdf_stage1 #(.N(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_r      (in_r),
    .in_i      (in_i),
    .out_valid (out_valid),
    .out_r     (out_r),
    .out_i     (out_i),
    .out_idx   (out_idx)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        q_idx.push_back(int'(out_idx));
        q_r.push_back(int'(out_r));
        q_i.push_back(int'(out_i));
      end
      if (!in_ready) lo_cnt++;
    end
  end

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic int wrap14(input int v);
    logic signed [13:0] t;
    t = v[13:0];
    return int'(t);
  endfunction

  function automatic int tw(input int k, input bit im);
    real a;
    real v;
    a = 2.0 * 3.14159265358979 * k / 32.0;
    v = im ? -64.0 * $sin(a) : 64.0 * $cos(a);
    return $rtoi($floor(v + 0.5));
  endfunction

  task automatic fill(input int mode);
    for (int j = 0; j < 32; j++) begin
      xr[j] = 0;
      xi[j] = 0;
      if (mode == 0) begin
        xr[j] = int'($urandom_range(0, 255)) - 128;
        xi[j] = int'($urandom_range(0, 255)) - 128;
      end
      if (mode == 2) xr[j] = 8;
    end
    if (mode == 1) xr[0] = 8;
    if (mode == 3) xr[16] = 8;
  endtask

  task automatic send(input int r, input int i);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_wait", 0, 1);
    in_valid = 1'b1;
    in_r     = 8'(r);
    in_i     = 8'(i);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_r     = 8'($urandom);
      in_i     = 8'($urandom);
    end
  endtask

  task automatic run_frame(input string name,
                           input int mode,
                           input int stall);
    int base;
    int n;
    int er;
    int ei;
    int dr;
    int di;
    int k;
    fill(mode);
    q_idx.delete();
    q_r.delete();
    q_i.delete();
    base = lo_cnt;
    for (int j = 0; j < 32; j++) begin
      if (stall == 1 && (j == 5 || j == 25)) gap(3);
      if (stall == 2 && $urandom_range(0, 7) == 0)
        gap(int'($urandom_range(1, 2)));
      send(xr[j], xi[j]);
    end
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (q_idx.size() < 32 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk({name, " count"}, q_idx.size(), 32);
    chk({name, " ready_low"}, lo_cnt - base, 16);
    for (int j = 0; j < 32 && j < q_idx.size(); j++) begin
      if (j < 16) begin
        er = wrap14((xr[j] + xr[j+16]) * 32);
        ei = wrap14((xi[j] + xi[j+16]) * 32);
      end else begin
        k  = j - 16;
        dr = xr[k] - xr[j];
        di = xi[k] - xi[j];
        er = wrap14((dr * tw(k, 0) - di * tw(k, 1)) >>> 1);
        ei = wrap14((dr * tw(k, 1) + di * tw(k, 0)) >>> 1);
      end
      chk($sformatf("%s idx[%0d]", name, j), q_idx[j], j);
      chk($sformatf("%s re[%0d]", name, j), q_r[j], er);
      chk($sformatf("%s im[%0d]", name, j), q_i[j], ei);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst out_r", int'(out_r), 0);
    chk("rst out_i", int'(out_i), 0);
    chk("rst out_idx", int'(out_idx), 0);
    chk("rst in_ready", int'(in_ready), 1);
    rst_n = 1'b1;

    run_frame("impulse", 1, 0);
    run_frame("const", 2, 0);
    run_frame("stall", 1, 1);
    run_frame("twiddle", 3, 0);
    run_frame("rand0", 0, 0);
    for (int f = 1; f < 5; f++)
      run_frame($sformatf("rand%0d", f), 0, 2);

    fill(1);
    for (int j = 0; j < 23; j++) send(xr[j], xi[j]);
    @(posedge clk);
    #2;
    chk("mid out_valid before rst", int'(out_valid), 1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_rst out_valid", int'(out_valid), 0);
    chk("mid_rst out_r", int'(out_r), 0);
    chk("mid_rst out_i", int'(out_i), 0);
    chk("mid_rst out_idx", int'(out_idx), 0);
    chk("mid_rst in_ready", int'(in_ready), 1);
    q_idx.delete();
    q_r.delete();
    q_i.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst no_output", q_idx.size(), 0);
    run_frame("post_rst", 1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
